// File: rtl/cnn_window_3x3.sv
// cnn_window_3x3: 3x3 sliding-window former for a raster 8-bit pixel stream.
// Two line buffers hold the previous two rows. Every full 3x3 neighbourhood
// (no padding) is registered out with the coordinates of its bottom-right
// pixel. An end-of-frame pulse follows the last pixel, and valid pixels that
// arrive after the frame is complete are dropped.
// Optional build macro: CNN_WIN_BINARIZE_EN. When it is defined, each pixel
// is thresholded against THRESH before buffering, so dark pixels (ink)
// become all-ones.
module cnn_window_3x3 #(
    parameter int IMG_W = 30,
    parameter int IMG_H = 30,
    parameter int PIX_W = 8
`ifdef CNN_WIN_BINARIZE_EN
    ,
    parameter logic [PIX_W-1:0] THRESH = 8'h80
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   pixel_i,
    input  logic               pixel_i_valid,
    input  logic               sof_i,
    output logic [9*PIX_W-1:0] win_o,
    output logic               win_valid_o,
    output logic [4:0]         win_x_o,
    output logic [4:0]         win_y_o,
    output logic               frame_done_o,
    output logic               drop_o
);

    localparam logic [4:0] COL_LAST = 5'(IMG_W - 1);
    localparam logic [4:0] ROW_LAST = 5'(IMG_H - 1);

    typedef enum logic {
        ACTIVE = 1'b0,
        DONE   = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [4:0]       col, row, col_next, row_next;
    logic [4:0]       col_eff, row_eff;
    logic             accept, emit, last_pix, drop;

    logic [PIX_W-1:0] pix;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    logic [PIX_W-1:0] linebuf0 [IMG_W];   // row-1
    logic [PIX_W-1:0] linebuf1 [IMG_W];   // row-2
    logic [PIX_W-1:0] win_q    [3][3];
    logic [PIX_W-1:0] win_next [3][3];
    logic [9*PIX_W-1:0] win_flat;

    // Pixel conditioning applied before anything is buffered.
`ifdef CNN_WIN_BINARIZE_EN
    assign pix = (pixel_i < THRESH) ? {PIX_W{1'b1}} : '0;
`else
    assign pix = pixel_i;
`endif

    // Accept/emit decisions, position advance and frame FSM next state.
    // NOTE: every signal driven here gets a value before any branch, so no
    // path can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        col_next   = col;
        row_next   = row;
        // A start of frame takes effect in the same cycle, so a pixel that
        // arrives alongside it lands at (0,0).
        col_eff    = sof_i ? 5'd0 : col;
        row_eff    = sof_i ? 5'd0 : row;
        accept     = pixel_i_valid && ((state == ACTIVE) || sof_i);
        emit       = accept && (row_eff >= 5'd2) && (col_eff >= 5'd2);
        last_pix   = accept && (col_eff == COL_LAST) && (row_eff == ROW_LAST);
        drop       = pixel_i_valid && (state == DONE) && !sof_i;

        if (sof_i) begin
            state_next = ACTIVE;
            col_next   = 5'd0;
            row_next   = 5'd0;
        end
        if (accept) begin
            if (col_eff == COL_LAST) begin
                col_next = 5'd0;
                row_next = row_eff + 5'd1;
            end else begin
                col_next = col_eff + 5'd1;
                row_next = row_eff;
            end
        end
        if (last_pix) begin
            state_next = DONE;
        end
    end

    // Next window: shift left one column; the new right column is
    // {row-2, row-1, current} at this column.
    always_comb begin
        lb0_rd   = linebuf0[col_eff];
        lb1_rd   = linebuf1[col_eff];
        win_flat = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                win_next[r][c] = win_q[r][c+1];
            end
        end
        win_next[0][2] = lb1_rd;
        win_next[1][2] = lb0_rd;
        win_next[2][2] = pix;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_flat[PIX_W*(3*r+c) +: PIX_W] = win_next[r][c];
            end
        end
    end

    // FSM state and position counters.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, whatever the block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACTIVE;
            col   <= 5'd0;
            row   <= 5'd0;
        end else begin
            state <= state_next;
            col   <= col_next;
            row   <= row_next;
        end
    end

    // Line buffers and the working window advance on every accepted pixel.
    // NOTE: this storage is deliberately left out of reset. No window is
    // emitted until rows 0 and 1 of the current frame have overwritten it,
    // so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            linebuf1[col_eff] <= lb0_rd;
            linebuf0[col_eff] <= pix;
            win_q             <= win_next;
        end
    end

    // Registered outputs. The window and coordinates load only on emit, so
    // they hold their values between windows.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_o        <= '0;
            win_x_o      <= 5'd0;
            win_y_o      <= 5'd0;
            win_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
            drop_o       <= 1'b0;
        end else begin
            win_valid_o  <= emit;
            frame_done_o <= last_pix;
            drop_o       <= drop;
            if (emit) begin
                win_o   <= win_flat;
                win_x_o <= col_eff;
                win_y_o <= row_eff;
            end
        end
    end

endmodule

// File: tb/tb_cnn_window_3x3.sv
// tb_cnn_window_3x3: randomized self-checking bench for cnn_window_3x3.
// The reference keeps a picture of the current frame in a 2-D array and cuts
// each 3x3 neighbourhood directly out of it.
module tb_cnn_window_3x3;

    localparam int W = 30;
    localparam int H = 30;

    logic        clk;
    logic        rst;
    logic [7:0]  pixel_i;
    logic        pixel_i_valid;
    logic        sof_i;
    logic [71:0] win_o;
    logic        win_valid_o;
    logic [4:0]  win_x_o;
    logic [4:0]  win_y_o;
    logic        frame_done_o;
    logic        drop_o;

    cnn_window_3x3 dut (
        .clk           (clk),
        .rst           (rst),
        .pixel_i       (pixel_i),
        .pixel_i_valid (pixel_i_valid),
        .sof_i         (sof_i),
        .win_o         (win_o),
        .win_valid_o   (win_valid_o),
        .win_x_o       (win_x_o),
        .win_y_o       (win_y_o),
        .frame_done_o  (frame_done_o),
        .drop_o        (drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: position inside the frame, completion flag, picture.
    int          m_x, m_y;
    bit          m_done;
    logic [7:0]  img [H][W];
    logic [71:0] exp_win;
    logic [4:0]  exp_x, exp_y;
    logic        exp_valid, exp_done, exp_drop;

    int n_cmp, n_err;
    int n_win, n_done, n_drop;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] px_map(input logic [7:0] p);
`ifdef CNN_WIN_BINARIZE_EN
        return (p < 8'h80) ? 8'hFF : 8'h00;
`else
        return p;
`endif
    endfunction

    // One clock: drive inputs, predict next-cycle outputs, compare after the edge.
    task automatic step(input logic r, input logic v, input logic [7:0] p, input logic s);
        bit acc;
        rst = r; pixel_i_valid = v; pixel_i = p; sof_i = s;
        exp_valid = 1'b0; exp_done = 1'b0; exp_drop = 1'b0;
        if (r) begin
            m_x = 0; m_y = 0; m_done = 0;
            exp_win = '0; exp_x = '0; exp_y = '0;
        end else begin
            if (s) begin
                m_x = 0; m_y = 0; m_done = 0;
            end else if (v && m_done) begin
                exp_drop = 1'b1;
            end
            acc = v && !m_done;
            if (acc) begin
                img[m_y][m_x] = px_map(p);
                if (m_x >= 2 && m_y >= 2) begin
                    exp_valid = 1'b1;
                    for (int rr = 0; rr < 3; rr++)
                        for (int cc = 0; cc < 3; cc++)
                            exp_win[8*(3*rr+cc) +: 8] = img[m_y-2+rr][m_x-2+cc];
                    exp_x = 5'(m_x);
                    exp_y = 5'(m_y);
                end
                if (m_x == W-1 && m_y == H-1) begin
                    exp_done = 1'b1;
                    m_done   = 1;
                end
                if (m_x == W-1) begin
                    m_x = 0; m_y++;
                end else begin
                    m_x++;
                end
            end
        end
        @(posedge clk);
        #1;
        check("win_valid", win_valid_o, exp_valid);
        check("frame_done", frame_done_o, exp_done);
        check("drop", drop_o, exp_drop);
        check("win", win_o, exp_win);
        check("win_x", win_x_o, exp_x);
        check("win_y", win_y_o, exp_y);
        if (win_valid_o) n_win++;
        if (frame_done_o) n_done++;
        if (drop_o) n_drop++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'($urandom), 1'b0);
    endtask

    // Pixel value for index i: 0 ramp, 1 random, 2 all-zero, 3 all-ones.
    function automatic logic [7:0] pix_val(input int vmode, input int i);
        case (vmode)
            0:       return 8'(i % 256);
            1:       return 8'($urandom);
            2:       return 8'h00;
            default: return 8'hFF;
        endcase
    endfunction

    // Full frame (sof on the first pixel). gap: 0 none, 1 alternate, 2 random.
    task automatic send_frame(input int gap, input int vmode, input int first_idx, input int count);
        logic [71:0] first_win;
        for (int i = first_idx; i < first_idx + count; i++) begin
            if (i != first_idx) begin
                if (gap == 1) idle();
                else if (gap == 2) repeat ($urandom_range(0, 2)) idle();
            end
            step(1'b0, 1'b1, pix_val(vmode, i), (i == first_idx) ? 1'b1 : 1'b0);
`ifndef CNN_WIN_BINARIZE_EN
            if (gap == 0 && vmode == 0 && first_idx == 0 && i == 2*W+2) begin
                first_win = {8'd62, 8'd61, 8'd60, 8'd32, 8'd31, 8'd30, 8'd2, 8'd1, 8'd0};
                check("ramp_first_valid", win_valid_o, 1'b1);
                check("ramp_first_win", win_o, first_win);
                check("ramp_first_x", win_x_o, 5'd2);
                check("ramp_first_y", win_y_o, 5'd2);
            end
`else
            if (vmode == 2 && win_valid_o) check("bin_ink", win_o, {72{1'b1}});
            if (vmode == 3 && win_valid_o) check("bin_paper", win_o, 72'd0);
`endif
        end
        idle();
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_win = 0; n_done = 0; n_drop = 0;
        m_x = 0; m_y = 0; m_done = 0;
        exp_win = '0; exp_x = '0; exp_y = '0;
        rst = 1'b1; pixel_i = '0; pixel_i_valid = 1'b0; sof_i = 1'b0;

        // Reset, with garbage valid pixels that must be ignored.
        repeat (3) step(1'b1, 1'b1, 8'($urandom), 1'b0);

        // Contiguous ramp frame.
        n_win = 0; n_done = 0;
        send_frame(0, 0, 0, W*H);
        check("ramp_windows", n_win, 784);
        check("ramp_frame_done", n_done, 1);

        // Overrun: extra valid pixels are dropped, no windows.
        n_win = 0; n_drop = 0;
        step(1'b0, 1'b1, 8'hAA, 1'b0);
        idle();
        step(1'b0, 1'b1, 8'h3C, 1'b0);
        check("overrun_windows", n_win, 0);
        check("overrun_drops", n_drop, 2);

        // Alternating-gap ramp frame.
        n_win = 0; n_done = 0;
        send_frame(1, 0, 0, W*H);
        check("gap_windows", n_win, 784);
        check("gap_frame_done", n_done, 1);

        // Random values with random gaps.
        for (int f = 0; f < 2; f++) begin
            n_win = 0; n_done = 0;
            send_frame(2, 1, 0, W*H);
            check("rand_windows", n_win, 784);
            check("rand_frame_done", n_done, 1);
        end

        // Mid-frame restart: 100 pixels, then sof with 8'h55, then 899 more.
        send_frame(0, 0, 0, 100);
        n_win = 0; n_done = 0;
        step(1'b0, 1'b1, 8'h55, 1'b1);
        for (int i = 1; i < W*H; i++) step(1'b0, 1'b1, pix_val(0, i), 1'b0);
        idle();
        check("restart_windows", n_win, 784);
        check("restart_frame_done", n_done, 1);

        // Reset mid-frame after 70 pixels, then a full random frame.
        send_frame(0, 1, 0, 70);
        repeat (2) step(1'b1, 1'b1, 8'($urandom), 1'b0);
        n_win = 0; n_done = 0;
        send_frame(2, 1, 0, W*H);
        check("rst_mid_windows", n_win, 784);
        check("rst_mid_frame_done", n_done, 1);

`ifdef CNN_WIN_BINARIZE_EN
        n_win = 0;
        send_frame(0, 2, 0, W*H);
        check("bin_zero_windows", n_win, 784);
        n_win = 0;
        send_frame(0, 3, 0, W*H);
        check("bin_ones_windows", n_win, 784);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
